// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: bit-level USB transmit engine. Serializes SYNC/PID/CRC/DATA
// fields LSB-first with bit stuffing and NRZI encoding, generates EOP, and
// reports each completed field with a one-clock *_bits_transmitted pulse.
module usb_tx_encoder #(
  parameter int         CLKS_PER_BIT = 8,
  parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sync_transmitting,
  input  logic        pid_transmitting,
  input  logic        crc5_transmitting,
  input  logic        crc16_transmitting,
  input  logic        data_transmitting,
  input  logic        eop_transmitting,
  input  logic [7:0]  tx_pid,
  input  logic [4:0]  tx_crc5,
  input  logic [15:0] tx_crc16,
  input  logic [63:0] tx_data,
  output logic        d_plus,
  output logic        d_minus,
  output logic        sync_bits_transmitted,
  output logic        pid_bits_transmitted,
  output logic        crc5_bits_transmitted,
  output logic        crc16_bits_transmitted,
  output logic        data_bits_transmitted,
  output logic        eop_bits_transmitted,
  output logic        tx_active
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST_CLK = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FIELD,
    STUFF,
    EOP_SE0_A,
    EOP_SE0_B,
    EOP_J
  } state_t;

  typedef enum logic [2:0] {
    F_SYNC,
    F_PID,
    F_CRC5,
    F_CRC16,
    F_DATA
  } field_t;

  state_t        state_q, state_d;
  field_t        field_q, field_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [63:0]   shift_q, shift_d;
  logic [6:0]    bitsLeft_q, bitsLeft_d;
  logic [2:0]    ones_q, ones_d;
  logic          dp_q, dp_d;
  logic          dm_q, dm_d;

  // Working values for the bit being launched this decision cycle
  logic [63:0]   srcBits;
  logic [6:0]    srcLen;
  logic [2:0]    onesBase;
  logic          emitBit;
  logic          lastClk;
  logic          fieldDone;

  // State, timer, shifter and line registers; reset parks the bus at J
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      field_q    <= F_SYNC;
      timer_q    <= '0;
      shift_q    <= '0;
      bitsLeft_q <= '0;
      ones_q     <= '0;
      dp_q       <= 1'b1;
      dm_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      bitsLeft_q <= bitsLeft_d;
      ones_q     <= ones_d;
      dp_q       <= dp_d;
      dm_q       <= dm_d;
    end
  end

  // Decision logic: at timer==0 choose the next line symbol (stuff, next bit,
  // EOP phase, or a new field by priority), otherwise just advance the timer
  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    shift_d    = shift_q;
    bitsLeft_d = bitsLeft_q;
    ones_d     = ones_q;
    dp_d       = dp_q;
    dm_d       = dm_q;
    srcBits    = shift_q;
    srcLen     = bitsLeft_q;
    onesBase   = ones_q;
    emitBit    = 1'b0;
    timer_d    = '0;

    if (timer_q == '0) begin
      if (state_q == FIELD && ones_q == 3'd6) begin
        state_d = STUFF;
        dp_d    = ~dp_q;
        dm_d    = ~dm_q;
        ones_d  = '0;
      end else if ((state_q == FIELD || state_q == STUFF) && bitsLeft_q != '0) begin
        emitBit = 1'b1;
      end else if (state_q == EOP_SE0_A) begin
        state_d = EOP_SE0_B;
      end else if (state_q == EOP_SE0_B) begin
        state_d = EOP_J;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
      end else if (state_q == EOP_J) begin
        state_d = IDLE;
        ones_d  = '0;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
      end else if (eop_transmitting) begin
        state_d = EOP_SE0_A;
        ones_d  = '0;
        dp_d    = 1'b0;
        dm_d    = 1'b0;
      end else if (sync_transmitting) begin
        emitBit  = 1'b1;
        field_d  = F_SYNC;
        srcBits  = {56'd0, SYNC_PATTERN};
        srcLen   = 7'd8;
        onesBase = '0;
      end else if (pid_transmitting) begin
        emitBit = 1'b1;
        field_d = F_PID;
        srcBits = {56'd0, tx_pid};
        srcLen  = 7'd8;
      end else if (crc5_transmitting) begin
        emitBit = 1'b1;
        field_d = F_CRC5;
        srcBits = {59'd0, tx_crc5};
        srcLen  = 7'd5;
      end else if (crc16_transmitting) begin
        emitBit = 1'b1;
        field_d = F_CRC16;
        srcBits = {48'd0, tx_crc16};
        srcLen  = 7'd16;
      end else if (data_transmitting) begin
        emitBit = 1'b1;
        field_d = F_DATA;
        srcBits = tx_data;
        srcLen  = 7'd64;
      end else begin
        state_d = IDLE;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
      end

      if (emitBit) begin
        state_d    = FIELD;
        shift_d    = srcBits >> 1;
        bitsLeft_d = srcLen - 7'd1;
        if (srcBits[0]) begin
          ones_d = onesBase + 3'd1;
          dp_d   = dp_q;
          dm_d   = dm_q;
        end else begin
          ones_d = '0;
          dp_d   = ~dp_q;
          dm_d   = ~dm_q;
        end
      end
    end

    if (state_d != IDLE) begin
      timer_d = (timer_q == LAST_CLK) ? '0 : timer_q + 1'b1;
    end
  end

  // Done pulses: final clock of a field's last bit period, after any owed stuff bit
  always_comb begin
    lastClk   = (timer_q == LAST_CLK);
    fieldDone = lastClk && (bitsLeft_q == '0) &&
                ((state_q == FIELD && ones_q != 3'd6) || state_q == STUFF);
    sync_bits_transmitted  = fieldDone && (field_q == F_SYNC);
    pid_bits_transmitted   = fieldDone && (field_q == F_PID);
    crc5_bits_transmitted  = fieldDone && (field_q == F_CRC5);
    crc16_bits_transmitted = fieldDone && (field_q == F_CRC16);
    data_bits_transmitted  = fieldDone && (field_q == F_DATA);
    eop_bits_transmitted   = lastClk && (state_q == EOP_J);
  end

  assign d_plus    = dp_q;
  assign d_minus   = dm_q;
  assign tx_active = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: table-driven check of usb_tx_encoder field timing,
// NRZI line levels, bit stuffing, EOP, priority and asynchronous reset.
module tb_usb_tx_encoder;

  localparam int CPB = 8;

  logic        clk;
  logic        n_rst;
  logic        sync_transmitting, pid_transmitting, crc5_transmitting;
  logic        crc16_transmitting, data_transmitting, eop_transmitting;
  logic [7:0]  tx_pid;
  logic [4:0]  tx_crc5;
  logic [15:0] tx_crc16;
  logic [63:0] tx_data;
  logic        d_plus, d_minus;
  logic        sync_bits_transmitted, pid_bits_transmitted, crc5_bits_transmitted;
  logic        crc16_bits_transmitted, data_bits_transmitted, eop_bits_transmitted;
  logic        tx_active;
  logic [5:0]  pulses;

  int errors = 0;
  int checks = 0;

  // Flag/pulse order everywhere: {eop, sync, pid, crc5, crc16, data}
  typedef struct {
    logic [5:0]  flags;
    logic [63:0] value;
    int          pulseIdx;
    int          nPeriods;
    logic [79:0] expDp;
    logic [79:0] expDm;
    int          dropAt;
  } vec_t;

  vec_t packet [8];
  vec_t extra [3];

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .SYNC_PATTERN(8'h80)) dut (
    .clk                    (clk),
    .n_rst                  (n_rst),
    .sync_transmitting      (sync_transmitting),
    .pid_transmitting       (pid_transmitting),
    .crc5_transmitting      (crc5_transmitting),
    .crc16_transmitting     (crc16_transmitting),
    .data_transmitting      (data_transmitting),
    .eop_transmitting       (eop_transmitting),
    .tx_pid                 (tx_pid),
    .tx_crc5                (tx_crc5),
    .tx_crc16               (tx_crc16),
    .tx_data                (tx_data),
    .d_plus                 (d_plus),
    .d_minus                (d_minus),
    .sync_bits_transmitted  (sync_bits_transmitted),
    .pid_bits_transmitted   (pid_bits_transmitted),
    .crc5_bits_transmitted  (crc5_bits_transmitted),
    .crc16_bits_transmitted (crc16_bits_transmitted),
    .data_bits_transmitted  (data_bits_transmitted),
    .eop_bits_transmitted   (eop_bits_transmitted),
    .tx_active              (tx_active)
  );

  assign pulses = {eop_bits_transmitted, sync_bits_transmitted, pid_bits_transmitted,
                   crc5_bits_transmitted, crc16_bits_transmitted, data_bits_transmitted};

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [5:0] f, input logic [63:0] v, input int pi,
                                 input int n, input logic [79:0] dp, input int dropAt,
                                 input bit isEop);
    vec_t r;
    r.flags    = f;
    r.value    = v;
    r.pulseIdx = pi;
    r.nPeriods = n;
    r.expDp    = dp;
    r.expDm    = isEop ? 80'd0 : (~dp & ((80'd1 << n) - 80'd1));
    r.dropAt   = dropAt;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [79:0] got,
                             input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s (vec %0d): got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic setFlags(input logic [5:0] f, input logic [63:0] v);
    {eop_transmitting, sync_transmitting, pid_transmitting,
     crc5_transmitting, crc16_transmitting, data_transmitting} = f;
    tx_pid   = v[7:0];
    tx_crc5  = v[4:0];
    tx_crc16 = v[15:0];
    tx_data  = v;
  endtask

  // Called at a negedge of a decision cycle (or in IDLE); returns at the
  // negedge of the next decision cycle with all flags dropped.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [79:0] gotDp;
    logic [79:0] gotDm;
    logic [5:0]  expPulse;
    int          pulseErrs;
    int          activeErrs;
    int          total;
    gotDp      = '0;
    gotDm      = '0;
    pulseErrs  = 0;
    activeErrs = 0;
    total      = v.nPeriods * CPB;
    setFlags(v.flags, v.value);
    for (int c = 1; c <= total; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c % CPB == CPB / 2) begin
        gotDp = gotDp | (80'(d_plus) << ((c - CPB / 2) / CPB));
        gotDm = gotDm | (80'(d_minus) << ((c - CPB / 2) / CPB));
      end
      expPulse = (c == total - 1) ? (6'b1 << v.pulseIdx) : 6'b0;
      if (pulses !== expPulse) begin
        pulseErrs++;
        if (pulseErrs == 1)
          $display("[TB] pulse deviation vec %0d cycle %0d: got %b, expected %b",
                   idx, c, pulses, expPulse);
      end
      if (tx_active !== 1'b1) activeErrs++;
      if (c == v.dropAt || c == total) setFlags(6'b0, v.value);
    end
    checkOutput("d_plus_seq", idx, gotDp, v.expDp);
    checkOutput("d_minus_seq", idx, gotDm, v.expDm);
    checkOutput("done_pulses", idx, 80'(pulseErrs), 80'd0);
    checkOutput("tx_active_during", idx, 80'(activeErrs), 80'd0);
  endtask

  initial begin
    int quietErrs;

    // Packet exercising every field, stuffing mid-field and trailing stuffing
    packet[0] = mkVec(6'b010000, 64'h0,    4, 8,  80'h2A,    0, 1'b0);
    packet[1] = mkVec(6'b001000, 64'hFF,   3, 9,  80'h1E0,   0, 1'b0);
    packet[2] = mkVec(6'b001000, 64'hA5,   3, 8,  80'hC9,    0, 1'b0);
    packet[3] = mkVec(6'b000100, 64'h1F,   2, 6,  80'h1F,    0, 1'b0);
    packet[4] = mkVec(6'b000100, 64'h1F,   2, 5,  80'h00,    0, 1'b0);
    packet[5] = mkVec(6'b000010, 64'h0001, 1, 17, 80'h0AAAA, 0, 1'b0);
    packet[6] = mkVec(6'b000001, 64'h3F,   0, 65, 80'h1_5555_5555_5555_5540, 0, 1'b0);
    packet[7] = mkVec(6'b100000, 64'h0,    5, 3,  80'h4,     0, 1'b1);
    // Priority (pid over data), flag dropped mid-field, sync after reset
    extra[0]  = mkVec(6'b001001, 64'hA5,   3, 8,  80'hC9,    0, 1'b0);
    extra[1]  = mkVec(6'b001000, 64'h00,   3, 8,  80'hAA,    20, 1'b0);
    extra[2]  = mkVec(6'b010000, 64'h0,    4, 8,  80'h2A,    0, 1'b0);

    n_rst = 1'b0;
    setFlags(6'b0, 64'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset_d_plus", 0, 80'(d_plus), 80'd1);
    checkOutput("reset_d_minus", 0, 80'(d_minus), 80'd0);
    checkOutput("reset_tx_active", 0, 80'(tx_active), 80'd0);
    checkOutput("reset_pulses", 0, 80'(pulses), 80'd0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_tx_active", 0, 80'(tx_active), 80'd0);

    for (int i = 0; i < 8; i++) applyStimulus(packet[i], i);

    // After EOP the block returns to IDLE on J
    @(negedge clk);
    checkOutput("post_eop_tx_active", 8, 80'(tx_active), 80'd0);
    checkOutput("post_eop_line", 8, 80'({d_plus, d_minus}), 80'b10);

    applyStimulus(extra[0], 9);
    applyStimulus(extra[1], 10);

    // Reset in the middle of data bit 20
    setFlags(6'b000001, 64'hDEAD_BEEF_0123_4567);
    repeat (20 * CPB + CPB / 2) @(negedge clk);
    checkOutput("mid_data_active", 11, 80'(tx_active), 80'd1);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("async_reset_line", 11, 80'({d_plus, d_minus}), 80'b10);
    checkOutput("async_reset_active", 11, 80'(tx_active), 80'd0);
    checkOutput("async_reset_pulses", 11, 80'(pulses), 80'd0);
    setFlags(6'b0, 64'h0);
    quietErrs = 0;
    repeat (2) begin
      @(negedge clk);
      if (pulses !== 6'b0 || tx_active !== 1'b0) quietErrs++;
    end
    n_rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (pulses !== 6'b0 || tx_active !== 1'b0) quietErrs++;
    end
    checkOutput("post_reset_quiet", 11, 80'(quietErrs), 80'd0);

    applyStimulus(extra[2], 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
